// File: rtl/cb_mem_bank_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// cb_mem_bank_cfg_ctrl
//
// Programming-side controller for a connection block's flat configuration
// memory. It takes a serial bitstream over a valid/ready handshake and writes
// the cells in ascending order. For each cell it first drives the bit line,
// then pulses the word line, then holds the bit line for one more cycle.
//
// Parameters
//   NUM_BITS  number of memory cells (bl/wl pairs) in the target block
//   WL_PULSE  word-line high time in prog_clk cycles (1..15)
//   CNT_W     width of cfg_bit_count / cell address (2**CNT_W > NUM_BITS)
//
// Ports
//   prog_clk       programming clock, the only clock
//   prog_reset_n   asynchronous active-low reset
//   cfg_start      single-cycle request to begin a programming pass
//   cfg_data_in    configuration bit, qualified by cfg_valid
//   cfg_valid      upstream bit valid
//   cfg_ready      controller accepts a bit this cycle
//   bl             bit lines; at most the addressed one is non-zero
//   wl             word lines; at most one is high at any time
//   cfg_busy       a programming pass is in progress
//   cfg_done       all NUM_BITS cells have been written
//   cfg_error      sticky: a bit was offered after the pass completed
//   cfg_bit_count  number of cells committed in the current pass
// ---------------------------------------------------------------------------
module cb_mem_bank_cfg_ctrl #(
  parameter int NUM_BITS = 66,
  parameter int WL_PULSE = 1,
  parameter int CNT_W    = 7
) (
  input  logic                prog_clk,
  input  logic                prog_reset_n,
  input  logic                cfg_start,
  input  logic                cfg_data_in,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  output logic [0:NUM_BITS-1] bl,
  output logic [0:NUM_BITS-1] wl,
  output logic                cfg_busy,
  output logic                cfg_done,
  output logic                cfg_error,
  output logic [CNT_W-1:0]    cfg_bit_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SETUP = 3'd2,
    PULSE = 3'd3,
    HOLD  = 3'd4,
    DONE  = 3'd5
  } state_e;

  // Four bits cover the full legal WL_PULSE range of 1..15.
  localparam int                PCNT_W     = 4;
  localparam logic [CNT_W-1:0]  LAST_ADDR  = CNT_W'(NUM_BITS - 1);
  localparam logic [PCNT_W-1:0] PULSE_LOAD = PCNT_W'(WL_PULSE - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    addr_q, addr_d;
  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
  logic [0:NUM_BITS-1] bl_q, bl_d;
  logic [0:NUM_BITS-1] wl_q, wl_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [CNT_W-1:0]    count_q, count_d;

  // Next-state and next-output logic. Every output is computed here together
  // with the state it belongs to, so each one comes straight from a flop
  // (cfg_ready in particular is the registered decode of "next state is LOAD").
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pcnt_d  = pcnt_q;
    bl_d    = bl_q;
    wl_d    = wl_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = done_q;
    error_d = error_q;
    count_d = count_q;

    unique case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d = LOAD;
          addr_d  = '0;
          count_d = '0;
          error_d = 1'b0;
          ready_d = 1'b1;
          busy_d  = 1'b1;
        end
      end

      LOAD: begin
        if (cfg_valid && ready_q) begin
          // Only the addressed bit line may carry the captured value.
          bl_d         = '0;
          bl_d[addr_q] = cfg_data_in;
          ready_d      = 1'b0;
          state_d      = SETUP;
        end
      end

      SETUP: begin
        // Bit line has been stable for one cycle; raise the word line next.
        wl_d         = '0;
        wl_d[addr_q] = 1'b1;
        pcnt_d       = PULSE_LOAD;
        state_d      = PULSE;
      end

      PULSE: begin
        if (pcnt_q == '0) begin
          wl_d    = '0;
          state_d = HOLD;
        end else begin
          pcnt_d = pcnt_q - PCNT_W'(1);
        end
      end

      HOLD: begin
        // Bit line was held through this cycle after wl fell; release it now.
        bl_d    = '0;
        count_d = count_q + CNT_W'(1);
        if (addr_q == LAST_ADDR) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          addr_d  = addr_q + CNT_W'(1);
          ready_d = 1'b1;
          state_d = LOAD;
        end
      end

      DONE: begin
        // A restart takes priority over flagging an over-supplied bit.
        if (cfg_start) begin
          state_d = LOAD;
          addr_d  = '0;
          count_d = '0;
          error_d = 1'b0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          ready_d = 1'b1;
        end else if (cfg_valid) begin
          error_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        addr_d  = '0;
        pcnt_d  = '0;
        bl_d    = '0;
        wl_d    = '0;
        ready_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        error_d = 1'b0;
        count_d = '0;
      end
    endcase
  end

  // State and output registers. Reset clears everything at once, which also
  // drops an active word line mid-pulse.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      pcnt_q  <= '0;
      bl_q    <= '0;
      wl_q    <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pcnt_q  <= pcnt_d;
      bl_q    <= bl_d;
      wl_q    <= wl_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      count_q <= count_d;
    end
  end

  assign cfg_ready     = ready_q;
  assign bl            = bl_q;
  assign wl            = wl_q;
  assign cfg_busy      = busy_q;
  assign cfg_done      = done_q;
  assign cfg_error     = error_q;
  assign cfg_bit_count = count_q;

endmodule

// File: tb/tb_cb_mem_bank_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cb_mem_bank_cfg_ctrl
//
// Drives two controllers (default pulse width and a 3-cycle pulse) with
// randomized and patterned bitstreams. A reference model keeps the expected
// cell image per controller and watches the bl/wl buses as a memory would:
// every word-line pulse must write the next cell, with the bit that was
// accepted for it, for exactly WL_PULSE cycles, framed by stable bit lines.
// ---------------------------------------------------------------------------
module tb_cb_mem_bank_cfg_ctrl;

  localparam int NB         = 66;
  localparam int CW         = 7;
  localparam int WIDE_PULSE = 3;

  logic          clk = 1'b0;
  logic          rstN;
  logic          startV  [2];
  logic          dataV   [2];
  logic          validV  [2];
  logic          readyV  [2];
  logic [0:NB-1] blV     [2];
  logic [0:NB-1] wlV     [2];
  logic          busyV   [2];
  logic          doneV   [2];
  logic          errorV  [2];
  logic [CW-1:0] countV  [2];

  int testsRun    = 0;
  int testsFailed = 0;
  int cyc         = 0;
  bit abortRun    = 1'b0;

  // Reference model state, one slot per controller.
  int            pulseW   [2];
  bit            expBits  [2][NB];
  int            accCnt   [2];
  int            expIdx   [2];
  int            pulseLen [2];
  int            startCyc [2];
  logic [0:NB-1] prevWl   [2];
  logic [0:NB-1] prevBl   [2];
  int            monIdx;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  cb_mem_bank_cfg_ctrl #(.NUM_BITS(NB), .WL_PULSE(1), .CNT_W(CW)) dut (
    .prog_clk      (clk),
    .prog_reset_n  (rstN),
    .cfg_start     (startV[0]),
    .cfg_data_in   (dataV[0]),
    .cfg_valid     (validV[0]),
    .cfg_ready     (readyV[0]),
    .bl            (blV[0]),
    .wl            (wlV[0]),
    .cfg_busy      (busyV[0]),
    .cfg_done      (doneV[0]),
    .cfg_error     (errorV[0]),
    .cfg_bit_count (countV[0])
  );

  cb_mem_bank_cfg_ctrl #(.NUM_BITS(NB), .WL_PULSE(WIDE_PULSE), .CNT_W(CW)) dutWide (
    .prog_clk      (clk),
    .prog_reset_n  (rstN),
    .cfg_start     (startV[1]),
    .cfg_data_in   (dataV[1]),
    .cfg_valid     (validV[1]),
    .cfg_ready     (readyV[1]),
    .bl            (blV[1]),
    .wl            (wlV[1]),
    .cfg_busy      (busyV[1]),
    .cfg_done      (doneV[1]),
    .cfg_error     (errorV[1]),
    .cfg_bit_count (countV[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory-side monitor, sampled on the falling edge. It treats each wl pulse
  // as a write of the next cell and checks it against the accepted bitstream.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rstN) begin
        expIdx[d]   = 0;
        pulseLen[d] = 0;
        prevWl[d]   = '0;
        prevBl[d]   = '0;
      end else begin
        checkOutput("lineShape", ($onehot0(wlV[d]) && ($countones(blV[d]) <= 1)), 1);
        if (wlV[d] != '0 && prevWl[d] == '0) begin
          monIdx = 0;
          for (int k = 0; k < NB; k++) if (wlV[d][k]) monIdx = k;
          checkOutput("wlOrder", monIdx, expIdx[d]);
          checkOutput("wlAfterAccept", expIdx[d] < accCnt[d], 1);
          if (expIdx[d] < NB) checkOutput("blData", blV[d][monIdx], expBits[d][expIdx[d]]);
          checkOutput("blSetup", blV[d] == prevBl[d], 1);
          pulseLen[d] = 1;
        end else if (wlV[d] != '0) begin
          pulseLen[d]++;
          checkOutput("pulseHeld", (blV[d] == prevBl[d]) && (wlV[d] == prevWl[d]), 1);
        end else if (prevWl[d] != '0) begin
          checkOutput("wlWidth", pulseLen[d], pulseW[d]);
          checkOutput("blHold", blV[d] == prevBl[d], 1);
          expIdx[d]++;
        end
        prevWl[d] = wlV[d];
        prevBl[d] = blV[d];
      end
    end
  end

  task automatic issueStart(input int d);
    if (abortRun) return;
    startV[d] = 1'b1;
    tick();
    startV[d] = 1'b0;
    startCyc[d] = cyc;
    accCnt[d]   = 0;
    expIdx[d]   = 0;
    checkOutput("startBusy",  busyV[d],  1);
    checkOutput("startReady", readyV[d], 1);
    checkOutput("startDone",  doneV[d],  0);
    checkOutput("startError", errorV[d], 0);
    checkOutput("startCount", countV[d], 0);
  endtask

  // Sends nBits bits. pattern 0: bit i = i[0], 1: all ones, other: random.
  // gapBit gets 5 idle cycles in LOAD before it is offered; startBit is
  // followed by a stray cfg_start pulse.
  task automatic applyStimulus(input int d, input int pattern, input int nBits,
                               input int gapBit, input int startBit);
    int lastAcc;
    int bound;
    bit b;
    lastAcc = -1;
    for (int i = 0; i < nBits && !abortRun; i++) begin
      case (pattern)
        0:       b = i[0];
        1:       b = 1'b1;
        default: b = 1'($urandom_range(0, 1));
      endcase
      dataV[d]  = b;
      validV[d] = (i == gapBit) ? 1'b0 : 1'b1;
      bound = 20;
      while (readyV[d] !== 1'b1 && bound > 0) begin
        tick();
        bound--;
      end
      if (bound == 0) begin
        checkOutput("readyTimeout", 0, 1);
        abortRun = 1'b1;
      end else begin
        checkOutput("countAtLoad", countV[d], i);
        checkOutput("linesIdleInLoad", (blV[d] == '0) && (wlV[d] == '0), 1);
        if (i == gapBit) begin
          repeat (5) begin
            tick();
            checkOutput("gapReady", readyV[d], 1);
            checkOutput("gapCount", countV[d], i);
            checkOutput("gapWl", wlV[d] == '0, 1);
          end
          validV[d] = 1'b1;
        end
        expBits[d][i] = b;
        accCnt[d]     = i + 1;
        tick();
        if (lastAcc >= 0 && i != gapBit) checkOutput("bitPeriod", cyc - lastAcc, 3 + pulseW[d]);
        lastAcc = cyc;
        checkOutput("readyAfterAccept", readyV[d], 0);
        if (i == startBit) begin
          startV[d] = 1'b1;
          tick();
          startV[d] = 1'b0;
        end
      end
    end
    validV[d] = 1'b0;
  endtask

  task automatic finishPass(input int d, input int extra);
    int bound;
    if (abortRun) return;
    bound = 2000;
    while (doneV[d] !== 1'b1 && bound > 0) begin
      tick();
      bound--;
    end
    if (bound == 0) begin
      checkOutput("doneTimeout", 0, 1);
      abortRun = 1'b1;
    end else begin
      checkOutput("passCycles", cyc - startCyc[d], NB * (3 + pulseW[d]) + extra);
      checkOutput("doneCount",  countV[d], NB);
      checkOutput("doneBusy",   busyV[d],  0);
      checkOutput("doneReady",  readyV[d], 0);
      checkOutput("doneError",  errorV[d], 0);
      checkOutput("cellsWritten", expIdx[d], NB);
    end
  endtask

  initial begin
    pulseW[0] = 1;
    pulseW[1] = WIDE_PULSE;
    rstN = 1'b0;
    for (int d = 0; d < 2; d++) begin
      startV[d] = 1'b0;
      dataV[d]  = 1'b0;
      validV[d] = 1'b0;
      accCnt[d] = 0;
    end
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      checkOutput("rstReady", readyV[d], 0);
      checkOutput("rstLines", (blV[d] == '0) && (wlV[d] == '0), 1);
      checkOutput("rstFlags", {busyV[d], doneV[d], errorV[d]}, 0);
      checkOutput("rstCount", countV[d], 0);
    end
    rstN = 1'b1;
    tick();

    // Reset in the middle of the word-line pulse for cell 10.
    issueStart(0);
    applyStimulus(0, 1, 11, -1, -1);
    if (!abortRun) begin
      tick();
      checkOutput("pulseAt10", wlV[0][10], 1);
      #2 rstN = 1'b0;
      #1;
      checkOutput("rstMidWl",    wlV[0] == '0, 1);
      checkOutput("rstMidBl",    blV[0] == '0, 1);
      checkOutput("rstMidBusy",  busyV[0], 0);
      checkOutput("rstMidCount", countV[0], 0);
      tick();
      tick();
      rstN = 1'b1;
      tick();
    end

    // Fresh full pass of ones after the reset.
    issueStart(0);
    applyStimulus(0, 1, NB, -1, -1);
    finishPass(0, 0);

    // Over-supply after DONE, then a restart that clears the flags.
    if (!abortRun) begin
      validV[0] = 1'b1;
      dataV[0]  = 1'b1;
      repeat (3) begin
        tick();
        checkOutput("overError", errorV[0], 1);
        checkOutput("overReady", readyV[0], 0);
        checkOutput("overDone",  doneV[0],  1);
        checkOutput("overWl",    wlV[0] == '0, 1);
        checkOutput("overCount", countV[0], NB);
      end
      validV[0] = 1'b0;
    end
    issueStart(0);
    applyStimulus(0, 0, NB, -1, -1);
    finishPass(0, 0);

    // Random bits with a 5-cycle gap before bit 20 and a stray start at bit 30.
    issueStart(0);
    applyStimulus(0, 2, NB, 20, 30);
    finishPass(0, 5);

    // Wider word-line pulse.
    issueStart(1);
    applyStimulus(1, 2, NB, -1, -1);
    finishPass(1, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
